// File: rtl/imem_boot_loader_if.sv
// Valid/ready word stream feeding the instruction-memory boot loader.
interface imem_boot_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Streams a counted program into imem, then releases the core
// from reset after a fixed settle delay.
module imem_boot_loader #(
  parameter int ADDR_WIDTH    = 8,
  parameter int START_ADDR    = 0,
  parameter int RELEASE_DELAY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_boot_loader_if.slave     stream,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [32:0] CAP =
    33'((64'd1 << ADDR_WIDTH) - 64'(START_ADDR));
  localparam int KW = ADDR_WIDTH + 1;
  localparam int DW = $clog2(RELEASE_DELAY + 1) + 1;

  typedef enum logic [2:0] {
    HEADER,
    LOAD,
    HOLD,
    RUN,
    ERROR
  } state_t;

  state_t                state, state_n;
  logic                  ready, ready_n;
  logic                  we_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [31:0]           wdata_n;
  logic                  cpu_reset_n;
  logic                  done_n;
  logic                  error_n;
  logic [KW-1:0]         n_q, n_n;
  logic [KW-1:0]         k_q, k_n;
  logic [DW-1:0]         dly_q, dly_n;
  logic                  xfer;

  assign stream.in_ready = ready;
  assign xfer = stream.in_valid && ready;

  always_comb begin
    state_n     = state;
    ready_n     = ready;
    we_n        = 1'b0;
    addr_n      = imem_addr;
    wdata_n     = imem_wdata;
    cpu_reset_n = cpu_reset;
    done_n      = done;
    error_n     = error;
    n_n         = n_q;
    k_n         = k_q;
    dly_n       = dly_q;
    unique case (state)
      HEADER: begin
        ready_n = 1'b1;
        if (xfer) begin
          if (stream.in_data == '0) begin
            state_n = HOLD;
            ready_n = 1'b0;
            // no write cycle to wait out, so the header cycle counts
            dly_n   = DW'(1);
          end else if ({1'b0, stream.in_data} > CAP) begin
            state_n = ERROR;
            ready_n = 1'b0;
            error_n = 1'b1;
          end else begin
            state_n = LOAD;
            n_n     = KW'(stream.in_data);
            k_n     = '0;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          we_n    = 1'b1;
          addr_n  = ADDR_WIDTH'(START_ADDR)
                  + k_q[ADDR_WIDTH-1:0];
          wdata_n = stream.in_data;
          k_n     = k_q + KW'(1);
          if (k_q + KW'(1) == n_q) begin
            state_n = HOLD;
            ready_n = 1'b0;
            dly_n   = '0;
          end
        end
      end
      HOLD: begin
        if (dly_q == DW'(RELEASE_DELAY)) begin
          state_n     = RUN;
          cpu_reset_n = 1'b0;
          done_n      = 1'b1;
        end else begin
          dly_n = dly_q + DW'(1);
        end
      end
      RUN, ERROR: begin
        ready_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HEADER;
      ready      <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= ADDR_WIDTH'(START_ADDR);
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      n_q        <= '0;
      k_q        <= '0;
      dly_q      <= '0;
    end else begin
      state      <= state_n;
      ready      <= ready_n;
      imem_we    <= we_n;
      imem_addr  <= addr_n;
      imem_wdata <= wdata_n;
      cpu_reset  <= cpu_reset_n;
      done       <= done_n;
      error      <= error_n;
      n_q        <= n_n;
      k_q        <= k_n;
      dly_q      <= dly_n;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader (ADDR_WIDTH=4, 16-word imem).
module tb_imem_boot_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  imem_boot_loader_if bus ();

  imem_boot_loader #(
    .ADDR_WIDTH    (AW),
    .START_ADDR    (0),
    .RELEASE_DELAY (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stream     (bus),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          fall_cyc[$];
  logic        prev_rst = 1'b1;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(int'(imem_addr));
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (prev_rst && !cpu_reset) fall_cyc.push_back(cyc);
    prev_rst = cpu_reset;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input int i);
    case (i)
      0:       data_of = 32'h2008_0005;
      1:       data_of = 32'h2009_0007;
      2:       data_of = 32'h0109_5020;
      default: data_of = 32'hC0DE_0000 | 32'(i);
    endcase
  endfunction

  task automatic do_reset(input bit chk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (chk) begin
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_imem_we", imem_we, 0);
      check("rst_imem_addr", imem_addr, 0);
      check("rst_imem_wdata", imem_wdata, 0);
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
    end
    reset = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w,
                           input bit gap,
                           output int at,
                           output bit ok);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    ok = 1'b0;
    at = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        at = cyc;
        ok = 1'b1;
        break;
      end
    end
    if (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [31:0] n;
    bit          gap;
    int          words;
    bit          exp_done;
    bit          exp_err;
    int          rel_gap;
  } vec_t;

  task automatic run_case(input vec_t v, input bit rst);
    int wb, fb, hdr_at, at, nw, ref_c;
    bit ok;
    if (rst) do_reset(1'b0);
    wb = wr_addr.size();
    fb = fall_cyc.size();
    send_word(v.n, v.gap, hdr_at, ok);
    check("hdr_accept", ok, 1);
    for (int i = 0; i < v.words; i++) begin
      send_word(data_of(i), v.gap, at, ok);
      if (!ok) begin
        check("word_accept", ok, 1);
        break;
      end
    end
    if (v.exp_err) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hDEAD_BEEF;
      repeat (5) begin
        @(negedge clk);
        check("err_in_ready", bus.in_ready, 0);
      end
    end
    bus.in_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done || error) begin
        ok = 1'b1;
        break;
      end
    end
    check("finish_in_time", ok, 1);
    repeat (6) @(negedge clk);
    nw = wr_addr.size() - wb;
    check("write_count", nw, v.words);
    for (int i = 0; i < nw && i < v.words; i++) begin
      check("write_addr", wr_addr[wb+i], i);
      check("write_data", wr_data[wb+i], data_of(i));
      if (!v.gap && i > 0)
        check("write_back_to_back",
              wr_cyc[wb+i] - wr_cyc[wb+i-1], 1);
    end
    check("done", done, v.exp_done);
    check("error", error, v.exp_err);
    check("cpu_reset", cpu_reset, !v.exp_done);
    check("idle_in_ready", bus.in_ready, 0);
    check("release_count", fall_cyc.size() - fb, v.exp_done);
    if (v.exp_done && fall_cyc.size() > fb) begin
      ref_c = (nw > 0) ? wr_cyc[wr_cyc.size()-1] : hdr_at;
      check("release_delay", fall_cyc[fb] - ref_c, v.rel_gap);
    end
  endtask

  vec_t tbl[8];

  initial begin
    int  wb, at;
    bit  ok;

    // rel_gap counts edges from the last write strobe (or from the
    // header transfer when N=0) to the edge that drops cpu_reset.
    tbl[0] = '{32'd3,          1'b0, 3,  1'b1, 1'b0, 4};
    tbl[1] = '{32'd3,          1'b1, 3,  1'b1, 1'b0, 4};
    tbl[2] = '{32'd0,          1'b0, 0,  1'b1, 1'b0, 3};
    tbl[3] = '{32'd16,         1'b0, 16, 1'b1, 1'b0, 4};
    tbl[4] = '{32'd17,         1'b0, 0,  1'b0, 1'b1, 0};
    tbl[5] = '{32'd1,          1'b1, 1,  1'b1, 1'b0, 4};
    tbl[6] = '{32'hFFFF_FFFF,  1'b0, 0,  1'b0, 1'b1, 0};
    tbl[7] = '{32'd15,         1'b1, 15, 1'b1, 1'b0, 4};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    do_reset(1'b1);
    @(posedge clk);
    #1;
    check("header_ready", bus.in_ready, 1);
    check("header_cpu_reset", cpu_reset, 1);

    for (int i = 0; i < 8; i++) run_case(tbl[i], 1'b1);

    // stream words after release must be ignored
    wb = wr_addr.size();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1234_5678;
    repeat (5) begin
      @(negedge clk);
      check("run_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    check("run_no_writes", wr_addr.size() - wb, 0);
    check("run_done", done, 1);

    // reset in the middle of a 5-word load
    do_reset(1'b0);
    wb = wr_addr.size();
    send_word(32'd5, 1'b0, at, ok);
    send_word(data_of(0), 1'b0, at, ok);
    send_word(data_of(1), 1'b0, at, ok);
    check("mid_we_before_rst", imem_we, 1);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_in_ready", bus.in_ready, 0);
    check("mid_cpu_reset", cpu_reset, 1);
    check("mid_we_cancel", imem_we, 0);
    check("mid_done", done, 0);
    reset = 1'b0;
    check("mid_write_count", wr_addr.size() - wb, 2);
    run_case('{32'd1, 1'b0, 1, 1'b1, 1'b0, 4}, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
